// File: rtl/shift_ex_stage_pkg.sv
// Shared definitions for the shift execute stage: opcode/funct constants,
// ShiftOper encoding, pipeline entry types and the instruction decoder.
package shift_ex_stage_pkg;

    localparam int OPERAND_WIDTH  = 16;
    localparam int REG_ADDR_WIDTH = 3;

    localparam logic [4:0] OP_ROLI        = 5'b10100;
    localparam logic [4:0] OP_SLLI        = 5'b10101;
    localparam logic [4:0] OP_RORI        = 5'b10110;
    localparam logic [4:0] OP_SRLI        = 5'b10111;
    localparam logic [4:0] OP_RTYPE_SHIFT = 5'b11010;

    localparam logic [1:0] FUNCT_ROL = 2'b00;
    localparam logic [1:0] FUNCT_SLL = 2'b01;
    localparam logic [1:0] FUNCT_ROR = 2'b10;
    localparam logic [1:0] FUNCT_SRL = 2'b11;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_ROL = 2'b10,
        SH_ROR = 2'b11
    } shift_oper_e;

    typedef struct packed {
        shift_oper_e                oper;
        logic [3:0]                 shamt;
        logic [OPERAND_WIDTH-1:0]   operand;
        logic [REG_ADDR_WIDTH-1:0]  rd;
        logic                       err;
    } s1_entry_t;

    typedef struct packed {
        logic [OPERAND_WIDTH-1:0]   result;
        logic [REG_ADDR_WIDTH-1:0]  rd;
        logic                       err;
    } s2_entry_t;

    // Illegal opcodes carry a zero operand so the shifter naturally yields 0x0000.
    function automatic s1_entry_t decode_shift(
        input logic [4:0]                opcode,
        input logic [1:0]                funct,
        input logic [3:0]                imm,
        input logic [3:0]                rt_amt,
        input logic [OPERAND_WIDTH-1:0]  rs,
        input logic [REG_ADDR_WIDTH-1:0] rd
    );
        s1_entry_t e;
        e.oper    = SH_SLL;
        e.shamt   = 4'd0;
        e.operand = rs;
        e.rd      = rd;
        e.err     = 1'b0;
        case (opcode)
            OP_ROLI: begin e.oper = SH_ROL; e.shamt = imm; end
            OP_SLLI: begin e.oper = SH_SLL; e.shamt = imm; end
            OP_RORI: begin e.oper = SH_ROR; e.shamt = imm; end
            OP_SRLI: begin e.oper = SH_SRL; e.shamt = imm; end
            OP_RTYPE_SHIFT: begin
                e.shamt = rt_amt;
                case (funct)
                    FUNCT_ROL: e.oper = SH_ROL;
                    FUNCT_SLL: e.oper = SH_SLL;
                    FUNCT_ROR: e.oper = SH_ROR;
                    default:   e.oper = SH_SRL;
                endcase
            end
            default: begin
                e.err     = 1'b1;
                e.operand = '0;
            end
        endcase
        return e;
    endfunction

endpackage

// File: rtl/shift_ex_stage_if.sv
// Decode-side and writeback-side handshake bundle of the shift execute stage.
import shift_ex_stage_pkg::*;

interface shift_ex_stage_if;
    logic                      in_valid;
    logic                      in_ready;
    logic [4:0]                in_opcode;
    logic [1:0]                in_funct;
    logic [3:0]                in_imm;
    logic [OPERAND_WIDTH-1:0]  in_rs_data;
    logic [OPERAND_WIDTH-1:0]  in_rt_data;
    logic [REG_ADDR_WIDTH-1:0] in_rd;
    logic                      out_valid;
    logic                      out_ready;
    logic [OPERAND_WIDTH-1:0]  out_result;
    logic [REG_ADDR_WIDTH-1:0] out_rd;
    logic                      out_err;

    // master: decode + writeback environment; slave: the stage itself
    modport master (
        output in_valid, in_opcode, in_funct, in_imm, in_rs_data, in_rt_data, in_rd,
        output out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_err
    );

    modport slave (
        input  in_valid, in_opcode, in_funct, in_imm, in_rs_data, in_rt_data, in_rd,
        input  out_ready,
        output in_ready, out_valid, out_result, out_rd, out_err
    );
endinterface

// File: rtl/shift_ex_stage_shifter.sv
// 16-bit barrel shifter: logical shifts zero-fill, rotates are exact modulo 16.
import shift_ex_stage_pkg::*;

module shift_ex_stage_shifter (
    input  logic [OPERAND_WIDTH-1:0] operand_i,
    input  shift_oper_e              oper_i,
    input  logic [3:0]               shamt_i,
    output logic [OPERAND_WIDTH-1:0] result_o
);
    logic [2*OPERAND_WIDTH-1:0] doubled;
    logic [2*OPERAND_WIDTH-1:0] dbl_left;
    logic [2*OPERAND_WIDTH-1:0] dbl_right;

    // Rotating a doubled copy lets one shifter serve both rotate directions.
    assign doubled   = {operand_i, operand_i};
    assign dbl_left  = doubled << shamt_i;
    assign dbl_right = doubled >> shamt_i;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        result_o = operand_i;
        case (oper_i)
            SH_SLL:  result_o = operand_i << shamt_i;
            SH_SRL:  result_o = operand_i >> shamt_i;
            SH_ROL:  result_o = dbl_left[2*OPERAND_WIDTH-1:OPERAND_WIDTH];
            default: result_o = dbl_right[OPERAND_WIDTH-1:0];
        endcase
    end
endmodule

// File: rtl/shift_ex_stage.sv
// Two-stage shift execute pipeline: S1 holds the decoded op, S2 the shifted result.
import shift_ex_stage_pkg::*;

module shift_ex_stage (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    shift_ex_stage_if.slave   bus
);
    logic        s1_valid_q, s1_valid_d;
    logic        s2_valid_q, s2_valid_d;
    s1_entry_t   s1_q, s1_d;
    s2_entry_t   s2_q, s2_d;
    s1_entry_t   decoded;
    logic [OPERAND_WIDTH-1:0] shifted;
    logic        s2_free;
    logic        s1_adv;
    logic        in_ready;
    logic        accept;
    logic        unused_rt_hi;

    assign unused_rt_hi = ^bus.in_rt_data[OPERAND_WIDTH-1:4];

    assign decoded = decode_shift(bus.in_opcode, bus.in_funct, bus.in_imm,
                                  bus.in_rt_data[3:0], bus.in_rs_data, bus.in_rd);

    shift_ex_stage_shifter u_shifter (
        .operand_i (s1_q.operand),
        .oper_i    (s1_q.oper),
        .shamt_i   (s1_q.shamt),
        .result_o  (shifted)
    );

    // No skid buffer: readiness follows out_ready combinationally when both stages are full.
    assign s2_free  = !s2_valid_q || bus.out_ready;
    assign s1_adv   = s1_valid_q && s2_free;
    assign in_ready = !rst && !flush && (!s1_valid_q || s2_free);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (s1_adv) begin
                s2_valid_d = 1'b1;
                s2_d       = '{result: shifted, rd: s1_q.rd, err: s1_q.err};
            end else if (bus.out_ready) begin
                s2_valid_d = 1'b0;
            end
            if (accept) begin
                s1_valid_d = 1'b1;
                s1_d       = decoded;
            end else if (s1_adv) begin
                s1_valid_d = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments; the data registers are
    // reset too because out_result/out_rd/out_err must read zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = s2_valid_q;
    assign bus.out_result = s2_q.result;
    assign bus.out_rd     = s2_q.rd;
    assign bus.out_err    = s2_q.err;
endmodule

// File: tb/tb_shift_ex_stage.sv
// Directed bench for shift_ex_stage: decode/shift vectors, backpressure,
// flush, illegal opcode and mid-operation reset.
import shift_ex_stage_pkg::*;

module tb_shift_ex_stage;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   total = 0;
    int   bad   = 0;

    shift_ex_stage_if bus ();

    shift_ex_stage dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [1:0] funct, input logic [3:0] imm,
                         input logic [15:0] rs, input logic [15:0] rt, input logic [2:0] rd);
        bus.in_valid   = 1'b1;
        bus.in_opcode  = op;
        bus.in_funct   = funct;
        bus.in_imm     = imm;
        bus.in_rs_data = rs;
        bus.in_rt_data = rt;
        bus.in_rd      = rd;
    endtask

    task automatic idle_in();
        bus.in_valid   = 1'b0;
        bus.in_opcode  = 5'b0;
        bus.in_funct   = 2'b0;
        bus.in_imm     = 4'b0;
        bus.in_rs_data = 16'h0;
        bus.in_rt_data = 16'h0;
        bus.in_rd      = 3'b0;
    endtask

    // One op with out_ready=1: accepted on the first edge, visible after the second.
    task automatic run_vec(input string tag, input logic [4:0] op, input logic [1:0] funct,
                           input logic [3:0] imm, input logic [15:0] rs, input logic [15:0] rt,
                           input logic [2:0] rd, input logic [15:0] exp, input logic exp_err);
        drive(op, funct, imm, rs, rt, rd);
        check({tag, ".in_ready"}, bus.in_ready, 1);
        tick();
        idle_in();
        check({tag, ".lat"}, bus.out_valid, 0);
        tick();
        check({tag, ".valid"}, bus.out_valid, 1);
        check({tag, ".result"}, bus.out_result, exp);
        check({tag, ".rd"}, bus.out_rd, rd);
        check({tag, ".err"}, bus.out_err, exp_err);
        tick();
        check({tag, ".drain"}, bus.out_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b1;
        idle_in();
        bus.in_valid = 1'b1;
        #1;
        check("rst.in_ready", bus.in_ready, 0);
        tick();
        tick();
        check("rst.in_ready2", bus.in_ready, 0);
        check("rst.out_valid", bus.out_valid, 0);
        check("rst.out_result", bus.out_result, 16'h0000);
        check("rst.out_rd", bus.out_rd, 0);
        check("rst.out_err", bus.out_err, 0);
        idle_in();
        rst = 1'b0;
        #1;
        check("rst.release_ready", bus.in_ready, 1);

        run_vec("slli1",   OP_SLLI,        2'b00,     4'd4,  16'h0001, 16'h0000, 3'd5, 16'h0010, 1'b0);
        run_vec("r_ror8",  OP_RTYPE_SHIFT, FUNCT_ROR, 4'd0,  16'h1234, 16'hFFF8, 3'd1, 16'h3412, 1'b0);
        run_vec("roli1",   OP_ROLI,        2'b00,     4'd1,  16'h8001, 16'h0000, 3'd2, 16'h0003, 1'b0);
        run_vec("rori15",  OP_RORI,        2'b00,     4'd15, 16'h0001, 16'h0000, 3'd3, 16'h0002, 1'b0);
        run_vec("srli15",  OP_SRLI,        2'b00,     4'd15, 16'h8000, 16'h0000, 3'd4, 16'h0001, 1'b0);
        run_vec("slli0",   OP_SLLI,        2'b00,     4'd0,  16'hBEEF, 16'h0000, 3'd6, 16'hBEEF, 1'b0);
        run_vec("roli8",   OP_ROLI,        2'b00,     4'd8,  16'h1234, 16'h0000, 3'd7, 16'h3412, 1'b0);
        run_vec("r_sll4",  OP_RTYPE_SHIFT, FUNCT_SLL, 4'd9,  16'h00FF, 16'h0004, 3'd0, 16'h0FF0, 1'b0);
        run_vec("r_srl3",  OP_RTYPE_SHIFT, FUNCT_SRL, 4'd0,  16'hF000, 16'hABC3, 3'd1, 16'h1E00, 1'b0);
        run_vec("r_rol4",  OP_RTYPE_SHIFT, FUNCT_ROL, 4'd0,  16'h1234, 16'h0004, 3'd2, 16'h2341, 1'b0);
        run_vec("illegal", 5'b00000,       2'b00,     4'd3,  16'hFFFF, 16'h0005, 3'd2, 16'h0000, 1'b1);

        // Backpressure: A, B, C back-to-back with writeback stalled.
        bus.out_ready = 1'b0;
        drive(OP_SLLI, 2'b00, 4'd1, 16'h0001, 16'h0, 3'd1);
        tick();
        drive(OP_SLLI, 2'b00, 4'd2, 16'h0001, 16'h0, 3'd2);
        tick();
        drive(OP_SLLI, 2'b00, 4'd3, 16'h0001, 16'h0, 3'd3);
        #1;
        check("bp.full_ready", bus.in_ready, 0);
        for (int i = 0; i < 4; i++) begin
            check("bp.hold_valid", bus.out_valid, 1);
            check("bp.hold_A", bus.out_result, 16'h0002);
            check("bp.hold_rd", bus.out_rd, 1);
            check("bp.hold_ready", bus.in_ready, 0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp.release_ready", bus.in_ready, 1);
        tick();
        idle_in();
        check("bp.B_valid", bus.out_valid, 1);
        check("bp.B", bus.out_result, 16'h0004);
        check("bp.B_rd", bus.out_rd, 2);
        tick();
        check("bp.C_valid", bus.out_valid, 1);
        check("bp.C", bus.out_result, 16'h0008);
        check("bp.C_rd", bus.out_rd, 3);
        tick();
        check("bp.empty", bus.out_valid, 0);

        // Flush with two entries in flight.
        bus.out_ready = 1'b0;
        drive(OP_SLLI, 2'b00, 4'd5, 16'h0001, 16'h0, 3'd4);
        tick();
        drive(OP_SLLI, 2'b00, 4'd6, 16'h0001, 16'h0, 3'd5);
        tick();
        idle_in();
        check("fl.pre_valid", bus.out_valid, 1);
        flush = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        check("fl.in_ready", bus.in_ready, 0);
        tick();
        flush = 1'b0;
        idle_in();
        check("fl.out_valid", bus.out_valid, 0);
        bus.out_ready = 1'b1;
        tick();
        check("fl.no_emit1", bus.out_valid, 0);
        tick();
        check("fl.no_emit2", bus.out_valid, 0);
        run_vec("fl.next", OP_SLLI, 2'b00, 4'd2, 16'h0003, 16'h0000, 3'd6, 16'h000C, 1'b0);

        // Reset while the output is stalled and S1 is occupied.
        bus.out_ready = 1'b0;
        drive(OP_SLLI, 2'b00, 4'd7, 16'h0001, 16'h0, 3'd7);
        tick();
        drive(OP_SRLI, 2'b00, 4'd1, 16'h0010, 16'h0, 3'd3);
        tick();
        idle_in();
        check("mr.pre_valid", bus.out_valid, 1);
        check("mr.pre_result", bus.out_result, 16'h0080);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        check("mr.in_ready", bus.in_ready, 0);
        tick();
        idle_in();
        check("mr.out_valid", bus.out_valid, 0);
        check("mr.out_result", bus.out_result, 16'h0000);
        check("mr.out_rd", bus.out_rd, 0);
        check("mr.out_err", bus.out_err, 0);
        check("mr.in_ready_hold", bus.in_ready, 0);
        rst = 1'b0;
        #1;
        check("mr.release_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        tick();
        check("mr.no_emit1", bus.out_valid, 0);
        tick();
        check("mr.no_emit2", bus.out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shift_ex_stage.md
Name: shift_ex_stage

Overview:
- Two-stage execute-side shift pipeline for the WISC-SP13 datapath.
- Accepts shift-class instructions from decode through a valid/ready handshake.
- Decodes opcode/funct into the shifter's ShiftOper/ShAmt encoding, runs the existing 16-bit barrel shifter, and registers the result for writeback.
- Provides stall (backpressure), flush, and illegal-op flagging.

Parameters:
- OPERAND_WIDTH, 16, data width; only 16 is supported.
- REG_ADDR_WIDTH, 3, destination register index width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  decode presents an instruction.
- in_ready  output  1  stage can accept this cycle.
- in_opcode  input  5  instruction bits [15:11].
- in_funct  input  2  instruction bits [1:0]; used by R-format only.
- in_imm  input  4  instruction bits [3:0]; immediate shift amount.
- in_rs_data  input  16  operand to shift.
- in_rt_data  input  16  R-format shift amount source; only bits [3:0] used.
- in_rd  input  3  destination register.
- flush  input  1  kills all in-flight entries.
- out_valid  output  1  result available.
- out_ready  input  1  writeback accepts.
- out_result  output  16  shifted/rotated value.
- out_rd  output  3  destination register of out_result.
- out_err  output  1  entry came from a non-shift opcode.

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high on rst; all state changes on the rising edge of clk.
- Reset values: out_valid=0, out_result=0, out_rd=0, out_err=0. Internal S1 valid=0. in_ready=0 while rst=1.
- Decode to ShiftOper (00 SLL, 01 SRL, 10 ROL, 11 ROR):
  - opcode 10100 ROLI -> 10; 10101 SLLI -> 00; 10110 RORI -> 11; 10111 SRLI -> 01; ShAmt=in_imm.
  - opcode 11010 R-format, in_funct 00 ROL -> 10, 01 SLL -> 00, 10 ROR -> 11, 11 SRL -> 01; ShAmt=in_rt_data[3:0].
  - Any other opcode: err=1, ShAmt=0, ShiftOper=00; the entry still flows down the pipe and is reported with out_result=0x0000.
- Shift semantics: logical shifts fill with 0. Rotates are exact modulo-16 for every ShAmt 0..15, including ShAmt[3]. Example: ROR by 8 of 0x1234 = 0x3412. ShAmt=0 passes the operand through unchanged.
- Pipeline:
  - S1 registers decoded op, operand, rd, err.
  - S2 registers shifter output, rd, err; S2 valid drives out_valid.
  - Latency: accept on cycle N -> out_valid on cycle N+2 if no stall. Throughput is 1 per cycle.
- Handshake:
  - Transfer in when in_valid & in_ready.
  - Transfer out when out_valid & out_ready.
  - s2_free = !out_valid | out_ready.
  - s1_adv = s1_valid & s2_free.
  - in_ready = !rst & !flush & (!s1_valid | s2_free).
  - Stalled registers hold their value. out_result, out_rd and out_err stay stable while out_valid & !out_ready.
  - in_ready is purely combinational. There is no skid buffer, so it drops in the same cycle out_ready drops with both stages full.
- Flush: on the next edge, S1 valid and out_valid both clear. Input is not accepted in the flush cycle (in_ready=0). An output handshake completing in the flush cycle still counts as delivered. Data registers may hold stale values but out_valid=0.
- Simultaneous events: rst has priority over flush; flush has priority over accept/advance.
- Reset mid-operation: all entries are discarded, nothing is emitted, and outputs return to reset values on the next edge.
- No combinational path from in_* to out_*.

Decomposition:
- Shared include shift_defs.vh holds:
  - opcode constants (OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI, OP_RTYPE_SHIFT);
  - funct constants;
  - ShiftOper codes (SH_SLL=2'b00, SH_SRL=2'b01, SH_ROL=2'b10, SH_ROR=2'b11).
- Sub-modules:
  - shift_decode: combinational; opcode/funct/imm/rt -> ShiftOper, ShAmt, err.
  - shifter: the existing barrel shifter, instantiated between S1 and S2.
- Registers are built from the codebase's dff cells.

Test Plan:
- SLLI rs=0x0001 imm=4 rd=5, out_ready=1 -> two cycles later out_valid=1, out_result=0x0010, out_rd=5, out_err=0.
- R-format ROR rs=0x1234 rt=0xFFF8 -> 0x3412; ROLI 0x8001 imm=1 -> 0x0003; RORI 0x0001 imm=15 -> 0x0002; SRLI 0x8000 imm=15 -> 0x0001; SLLI 0xBEEF imm=0 -> 0xBEEF.
- Backpressure: issue SLLI results A=0x0002, B=0x0004, C=0x0008 back-to-back, hold out_ready=0 for 4 cycles -> in_ready=0 once S1 and S2 are full, A is held stable on the output, then A, B, C emerge in order with no loss or duplication.
- Flush with two entries in flight -> out_valid=0 on the next edge, nothing emitted; the next accepted op appears 2 cycles after acceptance.
- Illegal opcode 00000 with rs=0xFFFF rd=2 -> out_valid=1, out_err=1, out_result=0x0000, out_rd=2.
- rst asserted while out_valid=1 and out_ready=0 -> the next edge gives out_valid=0, out_result=0, out_rd=0, out_err=0; in_ready=0 during rst and 1 the cycle after deassertion.
